// File: rtl/salt_pepper_pkg.sv
// Shared pixel/frame types for the salt-and-pepper filter datapath.
// Defaults describe a 640x480 8-bit grayscale stream.
package salt_pepper_pkg;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef logic [DEF_PIX_W-1:0]          pixel_t;
  typedef logic [$clog2(DEF_IMG_W)-1:0]  col_t;
  typedef logic [$clog2(DEF_IMG_H)-1:0]  row_t;
endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// Single-port line store: combinational read and registered write at the same address,
// so a write cycle returns the old word (read-before-write). Storage is not reset.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 interior windows; window appears 1 cycle after the pixel completing it.
// No backpressure: every in_valid pixel is consumed, downstream takes every win_valid pulse.
module window_3x3_gen
  import salt_pepper_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [PIX_W-1:0]         in_pixel,
  output logic [PIX_W-1:0]         px0,
  output logic [PIX_W-1:0]         px1,
  output logic [PIX_W-1:0]         px2,
  output logic [PIX_W-1:0]         px3,
  output logic [PIX_W-1:0]         px4,
  output logic [PIX_W-1:0]         px5,
  output logic [PIX_W-1:0]         px6,
  output logic [PIX_W-1:0]         px7,
  output logic [PIX_W-1:0]         px8,
  output logic                     win_valid,
  output logic [$clog2(IMG_W)-1:0] win_cx,
  output logic [$clog2(IMG_H)-1:0] win_cy,
  output logic                     frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]        col, x;
  logic [RW-1:0]        row, y;
  logic                 last_col, last_row;
  logic [2*PIX_W-1:0]   lb_rd, lb_wr;
  logic [PIX_W-1:0]     tap_top, tap_mid;
  logic [PIX_W-1:0]     win [9];

  // sof forces this pixel to (0,0) whatever the counters say
  assign x        = in_sof ? '0 : col;
  assign y        = in_sof ? '0 : row;
  assign last_col = (x == CW'(IMG_W - 1));
  assign last_row = (y == RW'(IMG_H - 1));

  // Upper half is row-2 (lb1), lower half row-1 (lb0); lb0 ages into lb1 on write
  assign tap_top = lb_rd[2*PIX_W-1:PIX_W];
  assign tap_mid = lb_rd[PIX_W-1:0];
  assign lb_wr   = {tap_mid, in_pixel};

  line_buffer #(.DEPTH(IMG_W), .WIDTH(2*PIX_W)) u_lb (
    .clk   (clk),
    .we    (in_valid),
    .addr  (x),
    .wdata (lb_wr),
    .rdata (lb_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : y + RW'(1);
      end else begin
        col <= x + CW'(1);
        row <= y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
      win_valid  <= 1'b0;
      win_cx     <= '0;
      win_cy     <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= in_valid && (x >= CW'(2)) && (y >= RW'(2));
      frame_done <= in_valid && last_col && last_row;
      if (in_valid) begin
        win[0] <= win[1]; win[1] <= win[2]; win[2] <= tap_top;
        win[3] <= win[4]; win[4] <= win[5]; win[5] <= tap_mid;
        win[6] <= win[7]; win[7] <= win[8]; win[8] <= in_pixel;
        win_cx <= x - CW'(1);
        win_cy <= y - RW'(1);
      end
    end
  end

  assign px0 = win[0];
  assign px1 = win[1];
  assign px2 = win[2];
  assign px3 = win[3];
  assign px4 = win[4];
  assign px5 = win[5];
  assign px6 = win[6];
  assign px7 = win[7];
  assign px8 = win[8];
endmodule
